// File: rtl/param_stack.sv
// Parametrised LIFO with owned pointer/count, replace, pick port and sticky errors.
// Define STACK_GUARD_EN for the guarded build; default build is circular (J1-compatible).
module param_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  input  logic [AW-1:0]    pick_idx,
  output logic [WIDTH-1:0] pick_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr, ptr_nxt, top_addr, pick_addr, wr_addr;
  logic [AW:0]      cnt_nxt;
  logic             wr_en, ovf_set, udf_set;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign top_addr  = ptr - PTR_ONE;
  assign pick_addr = top_addr - pick_idx;
  assign ovf_set   = push & ~pop & full;
  assign udf_set   = pop & empty;

`ifdef STACK_GUARD_EN
  assign tos       = empty ? '0 : mem[top_addr];
  assign pick_data = ({1'b0, pick_idx} >= count) ? '0 : mem[pick_addr];
`else
  assign tos       = mem[top_addr];
  assign pick_data = mem[pick_addr];
`endif

  // Replace on an empty stack degenerates to a plain push.
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_addr = ptr;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) begin
        ptr_nxt = ptr + PTR_ONE;
        cnt_nxt = CNT_ONE;
      end else begin
        wr_addr = top_addr;
      end
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        ptr_nxt = ptr + PTR_ONE;
        cnt_nxt = count + CNT_ONE;
      end else begin
`ifdef STACK_GUARD_EN
        wr_en = 1'b0;
`else
        wr_en   = 1'b1;
        ptr_nxt = ptr + PTR_ONE;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        ptr_nxt = ptr - PTR_ONE;
        cnt_nxt = count - CNT_ONE;
      end else begin
`ifdef STACK_GUARD_EN
        ptr_nxt = ptr;
`else
        ptr_nxt = ptr - PTR_ONE;
`endif
      end
    end
    if (resetq) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wd;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (resetq) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      count     <= cnt_nxt;
      overflow  <= (overflow & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | udf_set;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack (works with or without STACK_GUARD_EN).
module tb_param_stack;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] wd = '0;
  logic        clr_err = 1'b0;
  logic [15:0] tos;
  logic [3:0]  pick_idx = '0;
  logic [15:0] pick_data;
  logic [4:0]  count;
  logic        empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  param_stack #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .resetq(resetq), .push(push), .pop(pop), .wd(wd),
    .clr_err(clr_err), .tos(tos), .pick_idx(pick_idx), .pick_data(pick_data),
    .count(count), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of controls, then release them just after the edge.
  task automatic applyStimulus(input logic rst, input logic p, input logic q,
                               input logic [15:0] d, input logic c);
    resetq  = rst;
    push    = p;
    pop     = q;
    wd      = d;
    clr_err = c;
    @(posedge clk);
    #1;
    resetq  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic pickCheck(input string tag, input logic [3:0] idx,
                           input logic [15:0] expected);
    pick_idx = idx;
    #1;
    checkOutput(tag, 32'(pick_data), 32'(expected));
  endtask

  initial begin
    @(negedge clk);

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_udf", 32'(underflow), 32'd0);
`ifdef STACK_GUARD_EN
    checkOutput("rst_tos", 32'(tos), 32'd0);
    pickCheck("rst_pick", 4'd0, 16'h0);
`endif

    // Three pushes
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111, 1'b0);
    checkOutput("push1_tos", 32'(tos), 32'h1111);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h2222, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3333, 1'b0);
    checkOutput("push3_count", 32'(count), 32'd3);
    checkOutput("push3_tos", 32'(tos), 32'h3333);
    checkOutput("push3_empty", 32'(empty), 32'd0);
    pickCheck("push3_pick2", 4'd2, 16'h1111);
`ifdef STACK_GUARD_EN
    pickCheck("push3_pick5", 4'd5, 16'h0);
`endif

    // Replace top
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0);
    checkOutput("repl_count", 32'(count), 32'd3);
    checkOutput("repl_tos", 32'(tos), 32'hAAAA);
    pickCheck("repl_pick1", 4'd1, 16'h2222);
    checkOutput("repl_ovf", 32'(overflow), 32'd0);
    checkOutput("repl_udf", 32'(underflow), 32'd0);

    // Pop exposes the entry below
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    checkOutput("pop_count", 32'(count), 32'd2);
    checkOutput("pop_tos", 32'(tos), 32'h2222);

    // Fill to DEPTH then push once more
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'(i), 1'b0);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_ovf", 32'(overflow), 32'd0);
    checkOutput("fill_tos", 32'(tos), 32'h000F);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_full", 32'(full), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
`ifdef STACK_GUARD_EN
    checkOutput("ovf_tos", 32'(tos), 32'h000F);
    pickCheck("ovf_pick15", 4'd15, 16'h0000);
`else
    checkOutput("ovf_tos", 32'(tos), 32'hBEEF);
    pickCheck("ovf_pick15", 4'd15, 16'h0001);
`endif

    // Replace while full clears cleanly alongside clr_err
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1);
    checkOutput("replfull_ovf", 32'(overflow), 32'd0);
    checkOutput("replfull_count", 32'(count), 32'd16);
    checkOutput("replfull_tos", 32'(tos), 32'h5555);

    // Pop on empty, then clear
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    checkOutput("udf_flag", 32'(underflow), 32'd1);
    checkOutput("udf_count", 32'(count), 32'd0);
    checkOutput("udf_empty", 32'(empty), 32'd1);
`ifdef STACK_GUARD_EN
    checkOutput("udf_tos", 32'(tos), 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("udf_clear", 32'(underflow), 32'd0);

    // Replace on empty acts as push and flags underflow
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
    checkOutput("replempty_count", 32'(count), 32'd1);
    checkOutput("replempty_tos", 32'(tos), 32'h7777);
    checkOutput("replempty_udf", 32'(underflow), 32'd1);

    // Reset mid-stream with push asserted
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'(16'h10 + i), 1'b0);
    end
    checkOutput("mid_count5", 32'(count), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0099, 1'b0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0042, 1'b0);
    checkOutput("after_tos", 32'(tos), 32'h0042);
    checkOutput("after_count", 32'(count), 32'd1);

    // Set wins over clear
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    checkOutput("pop1_udf", 32'(underflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    checkOutput("udf2_flag", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    checkOutput("setwins_udf", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("final_clear", 32'(underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
